// File: rtl/adc_frame_controller.sv
// adc_frame_controller: frames the SPI ADC link at a fixed sample rate and streams each captured word
// Ports:
//   clk            system clock; s_clk is divided down from it
//   reset          asynchronous, active-low
//   enable         run sampling; only looked at on period ticks
//   s_clk, cs      registered serial clock and active-low chip-select to the ADC and spi_receiver
//   rx_data        spi_receiver data_out
//   sample, sample_valid, sample_ready   captured-sample valid/ready stream
//   overrun        sticky flag for a dropped capture; clear_overrun clears it (a new drop wins)
//   busy           high while a frame is in flight (SETUP through FLUSH)
module adc_frame_controller #(
    parameter int CLK_DIV       = 2,
    parameter int FRAME_BITS    = 16,
    parameter int SAMPLE_PERIOD = 1134,
    parameter int DATA_W        = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              s_clk,
    output logic              cs,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              clear_overrun,
    output logic              busy
);
    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CAPTURE, FLUSH, WAIT} state_t;

    state_t        state;
    logic [PW-1:0] period_cnt;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          tick;
    logic          div_done;

    assign tick     = enable && period_cnt == '0;
    assign div_done = div_cnt == D_LAST;

    always_ff @(posedge clk or negedge reset)
        if (!reset) period_cnt <= '0;
        else period_cnt <= (!enable || period_cnt == P_LAST) ? '0 : period_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s_clk        <= 1'b0;
            cs           <= 1'b1;
            busy         <= 1'b0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            // stream defaults; a capture in CAPTURE overrides both
            if (sample_valid && sample_ready) sample_valid <= 1'b0;
            if (clear_overrun) overrun <= 1'b0;
            div_cnt <= div_done ? '0 : div_cnt + 1'b1;
            case (state)
                IDLE, WAIT: begin
                    div_cnt <= '0;
                    if (tick) begin
                        state <= SETUP;
                        cs    <= 1'b0;
                        s_clk <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SETUP: if (div_done) begin
                    state   <= SHIFT;
                    s_clk   <= 1'b1;
                    bit_cnt <= '0;
                end
                // bit_cnt counts completed high/low pairs; the last low phase stays in SHIFT
                SHIFT: if (div_done) begin
                    if (s_clk) s_clk <= 1'b0;
                    else if (bit_cnt == B_LAST) state <= HOLD;
                    else begin
                        s_clk   <= 1'b1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                // cs is released one cycle before CAPTURE so the receiver word is settled
                HOLD: begin
                    if (cs) state <= CAPTURE;
                    else if (div_done) cs <= 1'b1;
                end
                CAPTURE: begin
                    if (!sample_valid || sample_ready) begin
                        sample       <= rx_data;
                        sample_valid <= 1'b1;
                    end else overrun <= 1'b1;
                    state   <= FLUSH;
                    s_clk   <= 1'b1;
                    div_cnt <= '0;
                end
                // one s_clk pulse with cs high clears the receiver bit counter
                FLUSH: if (div_done) begin
                    if (s_clk) s_clk <= 1'b0;
                    else begin
                        state <= WAIT;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_frame_controller.sv
// tb_adc_frame_controller: randomized check of adc_frame_controller against a frame-timeline model
module tb_adc_frame_controller;
    localparam int CD   = 2;
    localparam int FB   = 16;
    localparam int P    = 100;
    localparam int W    = 12;
    localparam int SH0  = 1 + CD;
    localparam int H0   = SH0 + 2 * CD * FB;
    localparam int CAP  = H0 + CD + 1;
    localparam int FEND = CAP + 2 * CD;
    localparam int LAT  = 1 + 2 * CD * (FB + 1) + 2;

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0, sample_ready = 1'b0, clear_overrun = 1'b0;
    logic s_clk, cs, sample_valid, overrun, busy;
    logic [W-1:0] rx_data, sample;

    adc_frame_controller #(.CLK_DIV(CD), .FRAME_BITS(FB), .SAMPLE_PERIOD(P), .DATA_W(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .s_clk(s_clk), .cs(cs), .rx_data(rx_data),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .clear_overrun(clear_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0]  adc_word = '0;
    logic [W-1:0]  rx_sr = '0;
    logic [5:0]    nfall = '0;
    logic [FB-1:0] frame_bits;
    assign frame_bits = {{(FB - W){1'b0}}, adc_word} << nfall;
    always @(negedge s_clk or posedge cs) nfall <= cs ? '0 : nfall + 1'b1;
    always @(posedge s_clk) if (!cs) rx_sr <= {rx_sr[W-2:0], frame_bits[FB-1]};
    assign rx_data = rx_sr;

    int errors = 0, checks = 0, cyc = 0;
    int m_pc = 0, m_off = -1, t_tick = 0, last_rise = -1, bits = 0, flushes = 0, rdy_mode = 0;
    logic [W-1:0] m_sample = '0, m_word = '0;
    logic m_valid = 1'b0, m_ovr = 1'b0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0, p_valid = 1'b0;
    logic en_ctl = 1'b0, clr_rand = 1'b0, clr_once = 1'b0, clr_at_cap = 1'b0, gap_chk = 1'b0;
    logic [W-1:0] words[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic sclk_exp(int off);
        return (off >= SH0 && off < H0 && ((off - SH0) / CD) % 2 == 0) || (off > CAP && off <= CAP + CD);
    endfunction

    task automatic step();
        logic drop, tick;
        @(negedge clk);
        cyc++;
        chk("cs", 32'(cs), 32'(!(m_off >= 1 && m_off <= CAP - 2)));
        chk("s_clk", 32'(s_clk), 32'(sclk_exp(m_off)));
        chk("busy", 32'(busy), 32'(m_off >= 1 && m_off <= FEND));
        chk("sample_valid", 32'(sample_valid), 32'(m_valid));
        chk("sample", 32'(sample), 32'(m_sample));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (cs != p_cs) chk("cs_edge_sclk_low", 32'(s_clk), 0);
        if (s_clk) chk("sclk_only_busy", 32'(busy), 1);
        if (!cs && p_cs) bits = 0;
        if (s_clk && !p_sclk) begin
            if (!cs) bits++;
            else flushes++;
        end
        if (cs && !p_cs) chk("frame_rising_edges", bits, FB);
        if (!busy && p_busy) begin
            chk("flush_edges", flushes, 1);
            flushes = 0;
        end
        if (sample_valid && !p_valid) begin
            chk("valid_latency", cyc - t_tick, LAT);
            if (gap_chk && last_rise >= 0) chk("valid_spacing", cyc - last_rise, P);
            last_rise = cyc;
        end
        p_cs = cs;
        p_sclk = s_clk;
        p_busy = busy;
        p_valid = sample_valid;
        enable = en_ctl;
        sample_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
        clear_overrun = clr_once || (clr_at_cap && m_off == CAP) || (clr_rand && $urandom_range(0, 7) == 0);
        clr_once = 1'b0;
        tick = enable && m_pc == 0 && m_off < 0;
        drop = m_off == CAP && m_valid && !sample_ready;
        if (m_off == CAP && !drop) begin
            m_sample = m_word;
            m_valid = 1'b1;
        end else if (m_valid && sample_ready) m_valid = 1'b0;
        m_ovr = drop ? 1'b1 : clear_overrun ? 1'b0 : m_ovr;
        m_pc = enable ? (m_pc + 1) % P : 0;
        m_off = tick ? 1 : (m_off >= 1 && m_off < FEND) ? m_off + 1 : -1;
        if (tick) begin
            m_word = words.size() > 0 ? words.pop_front() : W'($urandom);
            adc_word = m_word;
            t_tick = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_off(input int off);
        for (int i = 0; i < 2 * P && m_off != off; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_cs", 32'(cs), 1);
        chk("rst_s_clk", 32'(s_clk), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_sample", 32'(sample), 0);
        m_pc = 0;
        m_off = -1;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_sample = '0;
        p_cs = 1'b1;
        p_sclk = 1'b0;
        p_busy = 1'b0;
        p_valid = 1'b0;
        bits = 0;
        flushes = 0;
        en_ctl = 1'b0;
        enable = 1'b0;
        clear_overrun = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();
        words.push_back(12'hA5C);
        en_ctl = 1'b1;
        gap_chk = 1'b1;
        run(150);
        words.push_back(12'h123);
        words.push_back(12'hFED);
        words.push_back(12'h001);
        run(350);
        gap_chk = 1'b0;
        rdy_mode = 1;
        run(300);
        clr_once = 1'b1;
        run(100);
        clr_at_cap = 1'b1;
        run(100);
        clr_at_cap = 1'b0;
        rdy_mode = 0;
        run(100);
        rdy_mode = 2;
        clr_rand = 1'b1;
        run(600);
        clr_rand = 1'b0;
        rdy_mode = 0;
        wait_off(20);
        en_ctl = 1'b0;
        run(300);
        en_ctl = 1'b1;
        run(150);
        wait_off(30);
        do_reset();
        words.push_back(12'h5A3);
        en_ctl = 1'b1;
        run(150);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
